// File: rtl/proc_sequencer_if.sv
// Bus bundle between the sequencer and its host: run control, the
// instruction ROM port, the register display port and status flags.
// The master side is the sequencer itself; the slave side is the host/ROM.
interface proc_sequencer_if;
   logic        start;      // run request, looked at only in IDLE or HALT
   logic [4:0]  address;    // instruction ROM address (= pc)
   logic [22:0] code;       // instruction word, combinational from address
   logic [2:0]  reg_sel;    // register display selector
   logic [15:0] reg_data;   // contents of register reg_sel
   logic        busy;       // FETCH, EXEC or DIVIDE
   logic        halted;     // HALT state
   logic        illegal;    // sticky: an undefined opcode was executed
   logic [2:0]  dbg_state;  // current FSM state encoding, for observation

   modport master (
      input  start, code, reg_sel,
      output address, reg_data, busy, halted, illegal, dbg_state
   );

   modport slave (
      output start, code, reg_sel,
      input  address, reg_data, busy, halted, illegal, dbg_state
   );
endinterface

// File: rtl/proc_sequencer.sv
// Small 16-bit sequencer: fetches 23-bit instructions from a combinational
// ROM, executes register ops in two cycles and DIV/MOD through a 16-step
// restoring divider (18 cycles). Reset is synchronous, active low.
module proc_sequencer (
   input  logic                clk,
   input  logic                reset_n,
   proc_sequencer_if.master    bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_DIVIDE = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_LOAD = 4'b0001;
   localparam logic [3:0] OP_MOV  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_MOD  = 4'b1001;

   state_t      state_q, state_d;
   logic [4:0]  pc_q, pc_d;
   logic [22:0] ir_q, ir_d;
   logic        illegal_q, illegal_d;
   logic [15:0] regs_q [8];

   // Divider state: quotient/dividend shift register, partial remainder,
   // captured divisor and step counter.
   logic [15:0] dv_quo_q, dv_quo_d;
   logic [15:0] dv_rem_q, dv_rem_d;
   logic [15:0] dv_div_q, dv_div_d;
   logic [3:0]  dv_cnt_q, dv_cnt_d;

   // Register-file write port
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;

   // Instruction fields, always decoded from the latched instruction
   logic [3:0]  op;
   logic [2:0]  rd, rs;
   logic [15:0] imm;
   logic [15:0] rd_val, rs_val;

   assign op     = ir_q[22:19];
   assign rd     = ir_q[18:16];
   assign rs     = ir_q[15:13];
   assign imm    = ir_q[15:0];
   assign rd_val = regs_q[rd];
   assign rs_val = regs_q[rs];

   // One restoring-division step. With a zero divisor every trial succeeds,
   // so the quotient fills with ones (FFFF) and the remainder ends up equal
   // to the dividend, i.e. the original Rd.
   logic [16:0] rem_shift;
   logic [17:0] trial;
   logic        q_bit;
   logic [15:0] rem_next, quo_next;

   assign rem_shift = {dv_rem_q, dv_quo_q[15]};
   assign trial     = {1'b0, rem_shift} - {2'b00, dv_div_q};
   assign q_bit     = ~trial[17];
   assign rem_next  = q_bit ? trial[15:0] : rem_shift[15:0];
   assign quo_next  = {dv_quo_q[14:0], q_bit};

   // Next-state, datapath control and register-file write selection
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      illegal_d = illegal_q;
      dv_quo_d  = dv_quo_q;
      dv_rem_d  = dv_rem_q;
      dv_div_d  = dv_div_q;
      dv_cnt_d  = dv_cnt_q;
      rf_we     = 1'b0;
      rf_waddr  = rd;
      rf_wdata  = 16'h0000;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (bus.start) begin
               pc_d    = 5'd0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            ir_d    = bus.code;
            state_d = S_EXEC;
         end

         S_EXEC: begin
            pc_d    = pc_q + 5'd1;
            state_d = S_FETCH;
            case (op)
               OP_HALT: begin
                  pc_d    = pc_q;
                  state_d = S_HALT;
               end
               OP_LOAD: begin rf_we = 1'b1; rf_wdata = imm;             end
               OP_MOV:  begin rf_we = 1'b1; rf_wdata = rs_val;          end
               OP_ADD:  begin rf_we = 1'b1; rf_wdata = rd_val + rs_val; end
               OP_SUB:  begin rf_we = 1'b1; rf_wdata = rd_val - rs_val; end
               OP_XOR:  begin rf_we = 1'b1; rf_wdata = rd_val ^ rs_val; end
               OP_OR:   begin rf_we = 1'b1; rf_wdata = rd_val | rs_val; end
               OP_AND:  begin rf_we = 1'b1; rf_wdata = rd_val & rs_val; end
               OP_DIV, OP_MOD: begin
                  // Operands captured now, so rd == rs divides the old value
                  pc_d     = pc_q;
                  dv_quo_d = rd_val;
                  dv_rem_d = 16'h0000;
                  dv_div_d = rs_val;
                  dv_cnt_d = 4'd0;
                  state_d  = S_DIVIDE;
               end
               default: illegal_d = 1'b1;
            endcase
         end

         S_DIVIDE: begin
            dv_quo_d = quo_next;
            dv_rem_d = rem_next;
            dv_cnt_d = dv_cnt_q + 4'd1;
            if (dv_cnt_q == 4'd15) begin
               rf_we    = 1'b1;
               rf_wdata = (op == OP_DIV) ? quo_next : rem_next;
               pc_d     = pc_q + 5'd1;
               state_d  = S_FETCH;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, pc, instruction register, sticky flag and divider registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         pc_q      <= 5'd0;
         ir_q      <= 23'd0;
         illegal_q <= 1'b0;
         dv_quo_q  <= 16'h0000;
         dv_rem_q  <= 16'h0000;
         dv_div_q  <= 16'h0000;
         dv_cnt_q  <= 4'd0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         illegal_q <= illegal_d;
         dv_quo_q  <= dv_quo_d;
         dv_rem_q  <= dv_rem_d;
         dv_div_q  <= dv_div_d;
         dv_cnt_q  <= dv_cnt_d;
      end
   end

   // Register file: cleared by reset, which also drops any pending write
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= 16'h0000;
      end else if (rf_we) begin
         regs_q[rf_waddr] <= rf_wdata;
      end
   end

   assign bus.address   = pc_q;
   assign bus.reg_data  = regs_q[bus.reg_sel];
   assign bus.busy      = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                          (state_q == S_DIVIDE);
   assign bus.halted    = (state_q == S_HALT);
   assign bus.illegal   = illegal_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_proc_sequencer.sv
// Directed bench for proc_sequencer: reset, the 18-instruction program,
// illegal opcode, divide by zero, start held high, reset mid-divide and
// pc wrap. Expected values are hand-computed constants.
module tb_proc_sequencer;

   localparam logic [3:0] OP_HALT = 4'b0000;
   localparam logic [3:0] OP_LOAD = 4'b0001;
   localparam logic [3:0] OP_MOV  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_DIV  = 4'b1000;
   localparam logic [3:0] OP_MOD  = 4'b1001;
   localparam logic [3:0] OP_BAD  = 4'b1100;

   logic        clk;
   logic        reset_n;
   logic [22:0] rom [32];
   int          n_vec;
   int          n_bad;

   logic [15:0] exp_main [8] = '{16'hFFEB, 16'h0009, 16'h0009, 16'h0014,
                                 16'h0004, 16'h0003, 16'h0019, 16'h001E};
   logic [15:0] exp_zero [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                 16'h0000, 16'h0000, 16'h0000, 16'h0000};

   proc_sequencer_if bus ();

   proc_sequencer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   assign bus.code = rom[bus.address];

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [22:0] enc_ri(input logic [3:0] op,
                                          input logic [2:0] rd,
                                          input logic [15:0] imm);
      return {op, rd, imm};
   endfunction

   function automatic logic [22:0] enc_rr(input logic [3:0] op,
                                          input logic [2:0] rd,
                                          input logic [2:0] rs);
      return {op, rd, rs, 13'd0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_reg(input int sel, output logic [15:0] d);
      bus.reg_sel = 3'(sel);
      #0.5;
      d = bus.reg_data;
   endtask

   task automatic check_regs(input string tag, input logic [15:0] e [8]);
      logic [15:0] d;
      for (int i = 0; i < 8; i++) begin
         read_reg(i, d);
         chk($sformatf("%s_r%0d", tag, i), {16'h0, d}, {16'h0, e[i]});
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 32; i++) rom[i] = enc_ri(OP_HALT, 3'd0, 16'h0);
   endtask

   task automatic load_main();
      clear_rom();
      rom[0]  = enc_ri(OP_LOAD, 3'd7, 16'h001F);
      rom[1]  = enc_ri(OP_LOAD, 3'd5, 16'h00FE);
      rom[2]  = enc_rr(OP_AND,  3'd7, 3'd5);      // R7 = 001E
      rom[3]  = enc_ri(OP_LOAD, 3'd4, 16'h0004);
      rom[4]  = enc_ri(OP_LOAD, 3'd1, 16'h0024);
      rom[5]  = enc_rr(OP_DIV,  3'd1, 3'd4);      // R1 = 36/4 = 9
      rom[6]  = enc_rr(OP_MOV,  3'd2, 3'd1);      // R2 = 9
      rom[7]  = enc_rr(OP_MOV,  3'd5, 3'd7);      // R5 = 001E
      rom[8]  = enc_rr(OP_MOD,  3'd5, 3'd2);      // R5 = 30 mod 9 = 3
      rom[9]  = enc_ri(OP_LOAD, 3'd3, 16'h000A);
      rom[10] = enc_rr(OP_ADD,  3'd3, 3'd3);      // R3 = 0014
      rom[11] = enc_ri(OP_LOAD, 3'd6, 16'h002D);
      rom[12] = enc_rr(OP_SUB,  3'd6, 3'd3);      // R6 = 2D-14 = 0019
      rom[13] = enc_ri(OP_LOAD, 3'd0, 16'hFFE8);
      rom[14] = enc_rr(OP_OR,   3'd0, 3'd5);      // R0 = FFEB
      rom[15] = enc_rr(OP_XOR,  3'd4, 3'd2);      // R4 = 000D
      rom[16] = enc_rr(OP_XOR,  3'd4, 3'd2);      // R4 = 0004
      rom[17] = enc_rr(OP_AND,  3'd1, 3'd2);      // R1 = 0009
      rom[18] = enc_ri(OP_HALT, 3'd0, 16'h0);
   endtask

   // Start the program; cyc = rising edges after the start edge until halted
   task automatic run_prog(input bit hold, output int cyc);
      bus.start = 1'b1;
      tick();
      if (!hold) bus.start = 1'b0;
      cyc = 0;
      while (!bus.halted && cyc < 500) begin
         tick();
         cyc++;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          prev_addr;
      bit          wrapped;
      bit          busy_ok;
      logic [4:0]  wrap_addr;
      logic [15:0] d;

      n_vec       = 0;
      n_bad       = 0;
      reset_n     = 1'b0;
      bus.start   = 1'b1;   // start during reset must be ignored
      bus.reg_sel = 3'd0;
      clear_rom();

      // reset state
      repeat (3) tick();
      chk("rst_state",   {29'h0, bus.dbg_state}, 32'd0);
      chk("rst_busy",    {31'h0, bus.busy},      32'd0);
      chk("rst_halted",  {31'h0, bus.halted},    32'd0);
      chk("rst_illegal", {31'h0, bus.illegal},   32'd0);
      chk("rst_addr",    {27'h0, bus.address},   32'd0);
      check_regs("rst", exp_zero);
      bus.start = 1'b0;
      reset_n   = 1'b1;
      tick();

      // full program, single start pulse
      load_main();
      run_prog(1'b0, cyc);
      chk("prog_cycles",  cyc, 32'd70);
      chk("prog_addr",    {27'h0, bus.address}, 32'd18);
      chk("prog_illegal", {31'h0, bus.illegal}, 32'd0);
      check_regs("prog", exp_main);

      // illegal opcode then HALT; registers keep the program results
      clear_rom();
      rom[0] = enc_rr(OP_BAD, 3'd2, 3'd3);
      rom[1] = enc_ri(OP_HALT, 3'd0, 16'h0);
      run_prog(1'b0, cyc);
      chk("ill_cycles", cyc, 32'd4);
      chk("ill_flag",   {31'h0, bus.illegal}, 32'd1);
      chk("ill_addr",   {27'h0, bus.address}, 32'd1);
      check_regs("ill", exp_main);

      // divide by zero
      clear_rom();
      rom[0] = enc_ri(OP_LOAD, 3'd1, 16'h0007);
      rom[1] = enc_ri(OP_LOAD, 3'd2, 16'h0000);
      rom[2] = enc_rr(OP_DIV,  3'd1, 3'd2);
      rom[3] = enc_ri(OP_LOAD, 3'd3, 16'h0005);
      rom[4] = enc_rr(OP_MOD,  3'd3, 3'd2);
      rom[5] = enc_ri(OP_HALT, 3'd0, 16'h0);
      run_prog(1'b0, cyc);
      chk("dz_cycles", cyc, 32'd44);
      read_reg(1, d);
      chk("dz_div_r1", {16'h0, d}, 32'h0000FFFF);
      read_reg(3, d);
      chk("dz_mod_r3", {16'h0, d}, 32'h00000005);
      chk("dz_ill_sticky", {31'h0, bus.illegal}, 32'd1);

      // start held high for the whole program
      load_main();
      run_prog(1'b1, cyc);
      chk("hold_cycles", cyc, 32'd70);
      chk("hold_addr",   {27'h0, bus.address}, 32'd18);
      check_regs("hold", exp_main);

      // reset on the 5th DIVIDE cycle
      clear_rom();
      rom[0] = enc_ri(OP_LOAD, 3'd1, 16'd100);
      rom[1] = enc_ri(OP_LOAD, 3'd2, 16'd7);
      rom[2] = enc_rr(OP_DIV,  3'd1, 3'd2);
      rom[3] = enc_ri(OP_HALT, 3'd0, 16'h0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (10) tick();
      chk("mdiv_state_pre", {29'h0, bus.dbg_state}, 32'd3);
      read_reg(1, d);
      chk("mdiv_r1_pre", {16'h0, d}, 32'd100);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mdiv_state",   {29'h0, bus.dbg_state}, 32'd0);
      chk("mdiv_busy",    {31'h0, bus.busy},      32'd0);
      chk("mdiv_addr",    {27'h0, bus.address},   32'd0);
      chk("mdiv_illegal", {31'h0, bus.illegal},   32'd0);
      check_regs("mdiv", exp_zero);
      tick();

      // pc wrap: LOAD R0,i at every address, no HALT
      for (int i = 0; i < 32; i++) rom[i] = enc_ri(OP_LOAD, 3'd0, 16'(i));
      bus.reg_sel = 3'd0;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      wrapped   = 1'b0;
      busy_ok   = 1'b1;
      wrap_addr = 5'd31;
      for (int c = 0; c < 200 && !wrapped; c++) begin
         prev_addr = int'(bus.address);
         tick();
         if (!bus.busy) busy_ok = 1'b0;
         if (prev_addr == 31 && bus.address != 5'd31) begin
            wrapped   = 1'b1;
            wrap_addr = bus.address;
         end
      end
      #0.5;
      chk("wrap_seen", {31'h0, wrapped},   32'd1);
      chk("wrap_addr", {27'h0, wrap_addr}, 32'd0);
      chk("wrap_busy", {31'h0, busy_ok},   32'd1);
      chk("wrap_r0",   {16'h0, bus.reg_data}, 32'h0000001F);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have clock port clk: input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have reset port reset_n: input, 1 bit, synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have start: input, 1 bit, run request, sampled only in IDLE or HALT.
REQ-004 SHALL have address: output, 5 bits, instruction ROM address, driven directly from the program counter (pc).
REQ-005 SHALL have code: input, 23 bits, instruction word from the combinational ROM, valid in the same cycle as address.
REQ-006 SHALL have reg_sel: input, 3 bits, register-file read selector for display.
REQ-007 SHALL have reg_data: output, 16 bits, combinational contents of register reg_sel.
REQ-008 SHALL have busy: output, 1 bit, high in FETCH, EXEC and DIVIDE.
REQ-009 SHALL have halted: output, 1 bit, high in HALT.
REQ-010 SHALL have illegal: output, 1 bit, sticky flag for an executed undefined opcode.

Function
REQ-011 SHALL decode code as: op = code[22:19], rd = code[18:16], rs = code[15:13], imm = code[15:0].
REQ-012 SHALL contain an 8 x 16-bit register file R0-R7 and a 5-bit pc.
REQ-013 SHALL implement the FSM states IDLE, FETCH, EXEC, DIVIDE and HALT.
REQ-014 SHALL leave IDLE or HALT when start = 1: pc <= 0, next state FETCH; registers are retained.
REQ-015 SHALL in FETCH latch code into the instruction register, then go to EXEC.
REQ-016 SHALL in EXEC implement the opcodes as follows:
- 0000 HALT: go to HALT; pc unchanged.
- 0001 LOAD: Rd <= imm.
- 0010 MOV: Rd <= Rs.
- 0011 ADD: Rd <= Rd + Rs.
- 0100 SUB: Rd <= Rd - Rs.
- 0101 XOR: Rd <= Rd ^ Rs.
- 0110 OR: Rd <= Rd | Rs.
- 0111 AND: Rd <= Rd & Rs.
- 1000 DIV and 1001 MOD: latch the operands and go to DIVIDE.
- 1010-1111: no register write; set illegal.
REQ-017 SHALL compute all arithmetic modulo 2^16, unsigned, with carry and borrow discarded.
REQ-018 SHALL, for every non-HALT, non-DIVIDE opcode in EXEC, increment pc and go to FETCH; each such instruction takes 2 cycles.
REQ-019 SHALL in DIVIDE run a restoring divider for exactly 16 cycles, one quotient bit per cycle; on the 16th cycle it writes Rd (quotient for DIV, remainder for MOD), increments pc and goes to FETCH; DIV/MOD take 18 cycles in total.
REQ-020 SHALL handle divide by zero (Rs = 0) as: DIV writes Rd <= 16'hFFFF; MOD writes Rd <= the original Rd; both still take 18 cycles.
REQ-021 SHALL handle rd = rs in DIV/MOD as: the operands are captured before the write, and the result overwrites that register.
REQ-022 SHALL wrap pc from 31 to 0 on increment; execution continues with no halt.
REQ-023 SHALL ignore start while busy = 1.
REQ-024 SHALL hold address = pc in every state.
REQ-025 SHALL reflect a register-file write on reg_data in the cycle after the write edge.

Reset
REQ-026 SHALL, while reset_n = 0 at a clk rising edge, set: state IDLE, pc = 0, address = 0, R0-R7 = 0, instruction register = 0, divider state = 0, busy = 0, halted = 0, illegal = 0.
REQ-027 SHALL abort any instruction on reset, including mid-DIVIDE, with no partial register write.
REQ-028 SHALL take no action on start in the same cycle that reset_n = 0; reset has priority.

Verification
REQ-029 SHALL cover the full 18-instruction team ROM program: pulse start once -> halted rises at the 70th rising edge after the start edge, and the final registers are R0 = FFEB, R1 = 0009, R2 = 0009, R3 = 0014, R4 = 0004, R5 = 0003, R6 = 0019, R7 = 001E.
REQ-030 SHALL cover divide by zero: LOAD R1 7; LOAD R2 0; DIV R1 R2 -> R1 = FFFF; then LOAD R3 5; MOD R3 R2 -> R3 = 0005.
REQ-031 SHALL cover reset mid-division: assert reset_n = 0 on the 5th DIVIDE cycle -> next edge all registers 0, busy = 0, address = 0, state IDLE.
REQ-032 SHALL cover an illegal opcode: opcode 1100 at pc 0 followed by HALT -> illegal = 1, no register change, halted after 4 cycles.
REQ-033 SHALL cover pc wrap: a ROM with LOAD at all 32 addresses and no HALT -> address sequence 31 then 0; busy stays 1.
REQ-034 SHALL cover start ignored while busy: start held high throughout the ROM program -> identical results and timing to REQ-029, and no restart before HALT.
